// File: rtl/servo_pkg.sv
// Shared types for the servo motion sequencer: channel count,
// position type and sequencer state encoding.
package servo_pkg;
  localparam int NUM_CH = 5;
  localparam int POS_W  = 8;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    UPDATE,
    CHECK
  } seq_state_t;
endpackage

// File: rtl/frame_tick_gen.sv
// Frame timer: counts enabled cycles and pulses o_tick on the last
// cycle of each TICK_DIV-cycle frame, then wraps to zero.
// Ports: i_clk, i_reset (sync, high), i_en (count), i_clr (zero the
// count), o_tick (one-cycle, high while count == TICK_DIV-1 and enabled).
module frame_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);
endmodule

// File: rtl/servo_motion_sequencer.sv
// Five-channel servo pose sequencer: shadow/active target poses and a
// slew-limited ramp of pos_out toward the active pose, one step per frame.
// Ports: CLOCK_50, reset (sync, high); tgt_we/tgt_ch/tgt_pos shadow write;
// start/halt move control; pos_out (5x8, registered), busy, done (pulse).
module servo_motion_sequencer
  import servo_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int STEP     = 4,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 255,
  parameter int CENTER   = 128
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tgt_we,
  input  logic [2:0]  tgt_ch,
  input  logic [7:0]  tgt_pos,
  input  logic        start,
  input  logic        halt,
  output logic [39:0] pos_out,
  output logic        busy,
  output logic        done
);
  localparam pos_t       C_CTR   = pos_t'(CENTER);
  localparam pos_t       C_MIN   = pos_t'(POS_MIN);
  localparam pos_t       C_MAX   = pos_t'(POS_MAX);
  localparam pos_t       C_STEP8 = pos_t'(STEP);
  localparam logic [8:0] C_STEP9 = 9'(STEP);
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  pos_t       r_pos    [NUM_CH];
  pos_t       r_shadow [NUM_CH];
  pos_t       r_active [NUM_CH];
  seq_state_t r_state;
  logic [2:0] r_ch;
  logic       r_busy;
  logic       r_done;

  logic       w_tick;
  pos_t       w_clamped;
  pos_t       w_cur;
  pos_t       w_act;
  pos_t       w_mag;
  pos_t       w_next;
  logic [8:0] w_diff;
  logic       w_all_eq;

  frame_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk  (CLOCK_50),
    .i_reset(reset),
    .i_en   (r_state == WAIT_TICK),
    .i_clr  (halt),
    .o_tick (w_tick)
  );

  always_comb begin
    w_clamped = tgt_pos;
    if (int'(tgt_pos) < POS_MIN)      w_clamped = C_MIN;
    else if (int'(tgt_pos) > POS_MAX) w_clamped = C_MAX;
  end

  // Step never overshoots: magnitude is min(STEP, |active-pos|).
  always_comb begin
    w_cur  = r_pos[r_ch];
    w_act  = r_active[r_ch];
    w_diff = '0;
    w_mag  = '0;
    w_next = w_cur;
    if (w_cur < w_act) begin
      w_diff = {1'b0, w_act} - {1'b0, w_cur};
      w_mag  = (w_diff > C_STEP9) ? C_STEP8 : w_diff[7:0];
      w_next = w_cur + w_mag;
    end else if (w_cur > w_act) begin
      w_diff = {1'b0, w_cur} - {1'b0, w_act};
      w_mag  = (w_diff > C_STEP9) ? C_STEP8 : w_diff[7:0];
      w_next = w_cur - w_mag;
    end
  end

  // Pose-reached test including the channel being updated this cycle.
  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == int'(r_ch)) begin
        if (w_next != r_active[i]) w_all_eq = 1'b0;
      end else if (r_pos[i] != r_active[i]) begin
        w_all_eq = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pos[i]    <= C_CTR;
        r_shadow[i] <= C_CTR;
        r_active[i] <= C_CTR;
      end
      r_state <= IDLE;
      r_ch    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (tgt_we && (tgt_ch < 3'(NUM_CH))) begin
        r_shadow[tgt_ch] <= w_clamped;
      end
      if (halt && (r_state != IDLE)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (start && !halt) begin
              for (int i = 0; i < NUM_CH; i++) begin
                r_active[i] <= r_shadow[i];
              end
              r_state <= WAIT_TICK;
              r_busy  <= 1'b1;
            end
          end
          WAIT_TICK: begin
            if (w_tick) begin
              r_ch    <= '0;
              r_state <= UPDATE;
            end
          end
          UPDATE: begin
            r_pos[r_ch] <= w_next;
            if (r_ch == LAST_CH) begin
              r_state <= CHECK;
              r_done  <= w_all_eq;
            end else begin
              r_ch <= r_ch + 3'd1;
            end
          end
          CHECK: begin
            // r_done holds the pose-reached result for this frame
            if (r_done) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= WAIT_TICK;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pos_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos_out[8*i +: 8] = r_pos[i];
    end
  end

  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Bench for servo_motion_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a timeline model.
module tb_servo_motion_sequencer;
  localparam int TD   = 8;
  localparam int STP  = 4;
  localparam int PMIN = 0;
  localparam int PMAX = 250;
  localparam int CTR  = 128;
  localparam int PER  = TD + 6;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        tgt_we;
  logic [2:0]  tgt_ch;
  logic [7:0]  tgt_pos;
  logic        start;
  logic        halt;
  logic [39:0] pos_out;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  servo_motion_sequencer #(
    .TICK_DIV(TD),
    .STEP    (STP),
    .POS_MIN (PMIN),
    .POS_MAX (PMAX),
    .CENTER  (CTR)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .tgt_we  (tgt_we),
    .tgt_ch  (tgt_ch),
    .tgt_pos (tgt_pos),
    .start   (start),
    .halt    (halt),
    .pos_out (pos_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Timeline model: a move is a sequence of PER-cycle frames; edge t
  // after the start edge falls at phase (t-1)%PER of its frame.
  int m_pos [5];
  int m_sh  [5];
  int m_act [5];
  bit m_busy;
  bit m_done;
  bit m_ok = 1'b0;
  int m_t;

  function automatic int clampv(input int v);
    if (v < PMIN) return PMIN;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  function automatic int step_to(input int p, input int a);
    if (p < a) return p + (((a - p) < STP) ? (a - p) : STP);
    if (p > a) return p - (((p - a) < STP) ? (p - a) : STP);
    return p;
  endfunction

  function automatic logic [39:0] m_vec();
    logic [39:0] v;
    for (int i = 0; i < 5; i++) v[8*i +: 8] = 8'(m_pos[i]);
    return v;
  endfunction

  always @(posedge CLOCK_50) begin : model
    int ph;
    bit eq;
    bit go;
    if (reset === 1'b1) begin
      for (int i = 0; i < 5; i++) begin
        m_pos[i] = CTR;
        m_sh[i]  = CTR;
        m_act[i] = CTR;
      end
      m_busy = 0;
      m_done = 0;
      m_t    = 0;
      m_ok   = 1;
    end else if (m_ok) begin
      m_done = 0;
      go = !m_busy && start && !halt;
      if (m_busy && halt) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_t++;
        ph = (m_t - 1) % PER;
        if (ph >= TD && ph < TD + 5)
          m_pos[ph-TD] = step_to(m_pos[ph-TD], m_act[ph-TD]);
        eq = 1;
        for (int i = 0; i < 5; i++) if (m_pos[i] != m_act[i]) eq = 0;
        if (ph == TD + 4) m_done = eq;
        if (ph == TD + 5 && eq) m_busy = 0;
      end
      if (go) begin
        m_act  = m_sh;
        m_busy = 1;
        m_t    = 0;
      end
      if (tgt_we && tgt_ch < 3'd5) m_sh[tgt_ch] = clampv(int'(tgt_pos));
    end
  end

  always @(negedge CLOCK_50) begin : compare
    if (m_ok) begin
      n_tests++;
      if (pos_out !== m_vec() || busy !== m_busy || done !== m_done) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got pos=%h busy=%b done=%b want pos=%h busy=%b done=%b",
                 $time, pos_out, busy, done, m_vec(), m_busy, m_done);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int ch(input int k);
    return int'(pos_out[8*k +: 8]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic wr(input int c, input int p);
    tgt_we  = 1'b1;
    tgt_ch  = 3'(c);
    tgt_pos = 8'(p);
    @(negedge CLOCK_50);
    tgt_we  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    bit seen;
    seen = 0;
    k = 0;
    while (!seen && k < budget) begin
      @(negedge CLOCK_50);
      k++;
      seen = (done === 1'b1);
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done timeout after %0d cycles", budget);
    end
  endtask

  logic [39:0] all_ctr;

  initial begin
    int k;
    all_ctr = {5{8'd128}};
    reset = 1'b1; tgt_we = 0; tgt_ch = 0; tgt_pos = 0; start = 0; halt = 0;
    cyc(2);
    reset = 1'b0;
    chk("rst_pos", 64'(pos_out), 64'(all_ctr));
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);

    pulse_start();
    chk("t1_busy", 64'(busy), 1);
    wait_done(400, k);
    chk("t1_done_lat", k, 13);
    cyc(1);
    chk("t1_idle", 64'(busy), 0);

    wr(0, 138);
    pulse_start();
    cyc(9);  chk("t2_f1", ch(0), 132);
    cyc(14); chk("t2_f2", ch(0), 136);
    cyc(14); chk("t2_f3", ch(0), 138);
    cyc(4);
    chk("t2_done", 64'(done), 1);
    chk("t2_others", 64'(pos_out[39:8]), 64'({4{8'd128}}));
    cyc(1);
    chk("t2_busy_drop", 64'(busy), 0);

    wr(2, 120);
    wr(4, 200);
    pulse_start();
    cyc(11); chk("t3_ch2_f1", ch(2), 124);
    cyc(14); chk("t3_ch2_f2", ch(2), 120);
    wait_done(400, k);
    chk("t3_done_lat", k + 25, 251);
    chk("t3_ch4", ch(4), 200);
    chk("t3_ch2", ch(2), 120);
    cyc(1);

    wr(1, 255);
    pulse_start();
    wait_done(600, k);
    chk("t4_done_lat", k, 433);
    chk("t4_ch1_clamp", ch(1), 250);
    cyc(1);

    wr(3, 60);
    pulse_start();
    cyc(26); chk("t5_ch3_f2", ch(3), 120);
    halt = 1'b1;
    @(negedge CLOCK_50);
    halt = 1'b0;
    chk("t5_halt_busy", 64'(busy), 0);
    chk("t5_halt_hold", ch(3), 120);
    cyc(20);
    chk("t5_frozen", ch(3), 120);
    pulse_start();
    cyc(12); chk("t5_resume", ch(3), 116);
    wait_done(400, k);
    chk("t5_done_lat", k, 197);
    chk("t5_ch3_end", ch(3), 60);
    cyc(1);

    wr(0, 100);
    pulse_start();
    cyc(20);
    pulse_start();
    wr(0, 0);
    wait_done(400, k);
    chk("t6_done_lat", k, 117);
    chk("t6_ch0", ch(0), 100);
    cyc(1);
    pulse_start();
    cyc(9); chk("t6_next_f1", ch(0), 96);
    wait_done(600, k);
    chk("t6_next_lat", k, 340);
    chk("t6_ch0_zero", ch(0), 0);
    cyc(1);

    start = 1'b1; halt = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0; halt = 1'b0;
    chk("halt_beats_start", 64'(busy), 0);

    wr(0, 40);
    pulse_start();
    cyc(30);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("midmove_rst_pos", 64'(pos_out), 64'(all_ctr));
    chk("midmove_rst_busy", 64'(busy), 0);

    for (int i = 0; i < 6000; i++) begin
      tgt_we  = ($urandom_range(0, 4) == 0);
      tgt_ch  = 3'($urandom_range(0, 7));
      tgt_pos = 8'($urandom_range(0, 255));
      start   = ($urandom_range(0, 29) == 0);
      halt    = ($urandom_range(0, 199) == 0);
      reset   = ($urandom_range(0, 1499) == 0);
      @(negedge CLOCK_50);
    end
    tgt_we = 0; start = 0; halt = 0; reset = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
